multicycle_control_unit: RTL and testbench

//  Moore-FSM controller for the multicycle MIPS core: shared memory, IR, A/B/ALUOut regs.

---
 rtl/mc_ctrl_pkg.sv | 95 +++++++++
 rtl/mc_alu_decoder.sv | 35 +++
 rtl/multicycle_control_unit.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the FSM state type, opcode/func encodings, ALU operation codes,
// datapath select encodings and small instruction-classification helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecSh,
    StAluWb,
    StExecI,
    StIWb,
    StBranch,
    StJump,
    StJr,
    StTrap
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FuncSll  = 6'b000000;
  localparam logic [5:0] FuncSrl  = 6'b000010;
  localparam logic [5:0] FuncSra  = 6'b000011;
  localparam logic [5:0] FuncSllv = 6'b000100;
  localparam logic [5:0] FuncSrlv = 6'b000110;
  localparam logic [5:0] FuncSrav = 6'b000111;
  localparam logic [5:0] FuncJr   = 6'b001000;
  localparam logic [5:0] FuncAdd  = 6'b100000;
  localparam logic [5:0] FuncSub  = 6'b100010;
  localparam logic [5:0] FuncAnd  = 6'b100100;
  localparam logic [5:0] FuncOr   = 6'b100101;
  localparam logic [5:0] FuncSlt  = 6'b101010;

  // ALU operation codes (zero-extended to the configured width at the top)
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSll = 3'b011;
  localparam logic [2:0] AluSrl = 3'b100;
  localparam logic [2:0] AluSra = 3'b101;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcRegA   = 2'b11;

  // ALU operand A select
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcARegA  = 2'b01;
  localparam logic [1:0] SrcAShamt = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SrcBRegB   = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  // Register-operand R-type ALU ops (including variable shifts)
  function automatic logic is_r_alu(input logic [5:0] f);
    return f inside {FuncAdd, FuncSub, FuncAnd, FuncOr, FuncSlt, FuncSllv, FuncSrlv, FuncSrav};
  endfunction

  // Shamt-operand shifts
  function automatic logic is_r_shift(input logic [5:0] f);
    return f inside {FuncSll, FuncSrl, FuncSra};
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] f);
    case (op)
      OpRtype:                          return is_r_alu(f) | is_r_shift(f) | (f == FuncJr);
      OpLw, OpSw, OpBeq, OpBne, OpJ,
      OpAddi, OpAndi, OpOri:            return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type function-field to ALU operation decoder.
// Ports:
//   func      in   6           IR[5:0]
//   alu_ctrl  out  ALU_CTRL_W  ALU operation code, zero-extended above bit 2
// Unknown function codes decode to add; the FSM never routes them to an
// execute state, so the value only matters as a benign default.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic [5:0]            func,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
);

  logic [2:0] code;

  always_comb begin
    code = AluAdd;
    case (func)
      FuncAdd:           code = AluAdd;
      FuncSub:           code = AluSub;
      FuncAnd:           code = AluAnd;
      FuncOr:            code = AluOr;
      FuncSlt:           code = AluSlt;
      FuncSll, FuncSllv: code = AluSll;
      FuncSrl, FuncSrlv: code = AluSrl;
      FuncSra, FuncSrav: code = AluSra;
      default:           code = AluAdd;
    endcase
  end

  assign alu_ctrl = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style FSM controller for a multicycle MIPS datapath with a shared
// instruction/data memory, IR, A/B and ALUOut registers. Sequences each
// instruction through fetch/decode/execute/memory/writeback, stalling on the
// mem_ready handshake, and drives every datapath enable and mux select.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   operation, func             IR[31:26], IR[5:0]
//   zero                        ALU zero flag for the current cycle
//   mem_ready                   memory completes the current request
//   pc_we, pc_src               PC load and source select
//   iord                        memory address select (0 PC, 1 ALUOut)
//   mem_re, mem_we              memory read/write requests
//   ir_we                       IR load
//   reg_we, reg_write_addr/data register file write, dest (rt/rd), data (ALUOut/MDR)
//   imm_zext                    zero-extend immediate
//   alu_src_a, alu_src_b        ALU operand selects
//   alu_controller              ALU operation, ALU_CTRL_W bits
//   instr_done                  pulse in last state of each instruction
//   mem_err                     sticky memory timeout flag
//   illegal_op                  sticky illegal-instruction flag
//
// Parameters:
//   ALU_CTRL_W   ALU control width (>= 3)
//   MEM_TIMEOUT  max stalled cycles per request; 0 waits forever
//
// Build option: define MC_ILLEGAL_TRAP_EN to park in a trap state on an
// unknown instruction; otherwise unknown instructions retire as NOPs.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W  = 3,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            operation,
  input  logic [5:0]            func,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_we,
  output logic [1:0]            pc_src,
  output logic                  iord,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic                  ir_we,
  output logic                  reg_we,
  output logic                  reg_write_addr,
  output logic                  reg_write_data,
  output logic                  imm_zext,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_controller,
  output logic                  instr_done,
  output logic                  mem_err,
  output logic                  illegal_op
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [ALU_CTRL_W-1:0] AluAddW = ALU_CTRL_W'(AluAdd);
  localparam logic [ALU_CTRL_W-1:0] AluSubW = ALU_CTRL_W'(AluSub);
  localparam logic [ALU_CTRL_W-1:0] AluAndW = ALU_CTRL_W'(AluAnd);
  localparam logic [ALU_CTRL_W-1:0] AluOrW  = ALU_CTRL_W'(AluOr);

`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_t StIllegal = StTrap;
`else
  localparam state_t StIllegal = StFetch;
`endif

  state_t                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    mem_err_q, mem_err_d;
  logic [ALU_CTRL_W-1:0]   alu_r;
  logic                    stall;
  logic                    timeout;
  logic                    decode_legal;
  logic                    zext_op;

  mc_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_dec (
    .func    (func),
    .alu_ctrl(alu_r)
  );

  assign decode_legal = is_legal(operation, func);
  assign zext_op      = (operation == OpAndi) || (operation == OpOri);

  // Only the three request-issuing states can stall; mem_ready elsewhere is ignored.
  assign stall   = (state_q inside {StFetch, StMemRd, StMemWr}) && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && stall && (cnt_q == CntW'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    cnt_d     = '0;
    mem_err_d = mem_err_q | timeout;
    if (MEM_TIMEOUT != 0 && stall && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (!decode_legal) begin
          state_d = StIllegal;
        end else begin
          unique case (operation)
            OpLw, OpSw:            state_d = StMemAdr;
            OpBeq, OpBne:          state_d = StBranch;
            OpAddi, OpAndi, OpOri: state_d = StExecI;
            OpJ:                   state_d = StJump;
            OpRtype: begin
              if (func == FuncJr)        state_d = StJr;
              else if (is_r_shift(func)) state_d = StExecSh;
              else                       state_d = StExecR;
            end
            default:               state_d = StIllegal;
          endcase
        end
      end
      StMemAdr: state_d = (operation == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExecR,
      StExecSh: state_d = StAluWb;
      StExecI:  state_d = StIWb;
      StMemWb, StAluWb, StIWb,
      StBranch, StJump, StJr: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
    // An expired wait abandons the request and restarts at fetch.
    if (timeout) state_d = StFetch;
  end

  // Output decode
  always_comb begin
    pc_we          = 1'b0;
    pc_src         = PcSrcAlu;
    iord           = 1'b0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    ir_we          = 1'b0;
    reg_we         = 1'b0;
    reg_write_addr = 1'b0;
    reg_write_data = 1'b0;
    imm_zext       = 1'b0;
    alu_src_a      = SrcAPc;
    alu_src_b      = SrcBRegB;
    alu_controller = AluAddW;
    instr_done     = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_re    = 1'b1;
        alu_src_b = SrcBFour;
        pc_we     = mem_ready;
        ir_we     = mem_ready;
      end
      StDecode: begin
        // Speculative branch target into ALUOut
        alu_src_b = SrcBImmSh2;
`ifndef MC_ILLEGAL_TRAP_EN
        instr_done = !decode_legal;
`endif
      end
      StMemAdr: begin
        alu_src_a = SrcARegA;
        alu_src_b = SrcBImm;
      end
      StMemRd: begin
        mem_re = 1'b1;
        iord   = 1'b1;
      end
      StMemWb: begin
        reg_we         = 1'b1;
        reg_write_data = 1'b1;
        instr_done     = 1'b1;
      end
      StMemWr: begin
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      StExecR: begin
        alu_src_a      = SrcARegA;
        alu_controller = alu_r;
      end
      StExecSh: begin
        alu_src_a      = SrcAShamt;
        alu_controller = alu_r;
      end
      StAluWb: begin
        reg_we         = 1'b1;
        reg_write_addr = 1'b1;
        instr_done     = 1'b1;
      end
      StExecI: begin
        alu_src_a = SrcARegA;
        alu_src_b = SrcBImm;
        imm_zext  = zext_op;
        if (operation == OpAndi)     alu_controller = AluAndW;
        else if (operation == OpOri) alu_controller = AluOrW;
        else                         alu_controller = AluAddW;
      end
      StIWb: begin
        reg_we     = 1'b1;
        imm_zext   = zext_op;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a      = SrcARegA;
        alu_controller = AluSubW;
        pc_src         = PcSrcAluOut;
        pc_we          = ((operation == OpBeq) && zero) || ((operation == OpBne) && !zero);
        instr_done     = 1'b1;
      end
      StJump: begin
        pc_we      = 1'b1;
        pc_src     = PcSrcJump;
        instr_done = 1'b1;
      end
      StJr: begin
        pc_we      = 1'b1;
        pc_src     = PcSrcRegA;
        instr_done = 1'b1;
      end
      StTrap: begin
      end
      default: begin
      end
    endcase

    // Strobes and selects go quiet the moment reset asserts, not at the next edge.
    if (!rst_n) begin
      pc_we          = 1'b0;
      pc_src         = PcSrcAlu;
      iord           = 1'b0;
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      ir_we          = 1'b0;
      reg_we         = 1'b0;
      reg_write_addr = 1'b0;
      reg_write_data = 1'b0;
      imm_zext       = 1'b0;
      alu_src_a      = SrcAPc;
      alu_src_b      = SrcBRegB;
      alu_controller = AluAddW;
      instr_done     = 1'b0;
    end
  end

  assign mem_err = mem_err_q;

`ifdef MC_ILLEGAL_TRAP_EN
  // TRAP is only left through reset, so the flag is sticky by construction.
  assign illegal_op = (state_q == StTrap);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (MEM_TIMEOUT = 4).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] operation = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_we, iord, mem_re, mem_we, ir_we, reg_we;
  logic       reg_write_addr, reg_write_data, imm_zext, instr_done, mem_err, illegal_op;
  logic [1:0] pc_src, alu_src_a, alu_src_b;
  logic [2:0] alu_controller;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .ALU_CTRL_W (3),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .operation     (operation),
    .func          (func),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_we         (pc_we),
    .pc_src        (pc_src),
    .iord          (iord),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .ir_we         (ir_we),
    .reg_we        (reg_we),
    .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data),
    .imm_zext      (imm_zext),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_controller(alu_controller),
    .instr_done    (instr_done),
    .mem_err       (mem_err),
    .illegal_op    (illegal_op)
  );

  // Instruction classes of the reference model
  localparam int CLw = 0, CSw = 1, CR = 2, CSh = 3, CI = 4, CBr = 5, CJ = 6, CJr = 7, CBad = 8;

  logic [11:0] instr_tbl [20] = '{
    {6'b100011, 6'd0}, {6'b101011, 6'd0}, {6'b000100, 6'd0}, {6'b000101, 6'd0},
    {6'b001000, 6'd0}, {6'b001100, 6'd0}, {6'b001101, 6'd0}, {6'b000010, 6'd0},
    {6'b000000, 6'b001000}, {6'b000000, 6'b100000}, {6'b000000, 6'b100010},
    {6'b000000, 6'b100100}, {6'b000000, 6'b100101}, {6'b000000, 6'b101010},
    {6'b000000, 6'b000100}, {6'b000000, 6'b000110}, {6'b000000, 6'b000111},
    {6'b000000, 6'b000000}, {6'b000000, 6'b000010}, {6'b000000, 6'b000011}
  };

  function automatic int ref_class(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return CLw;
      6'b101011: return CSw;
      6'b000100, 6'b000101: return CBr;
      6'b001000, 6'b001100, 6'b001101: return CI;
      6'b000010: return CJ;
      6'b000000: begin
        if (fn == 6'b001000) return CJr;
        if (fn inside {6'b000000, 6'b000010, 6'b000011}) return CSh;
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                       6'b000100, 6'b000110, 6'b000111}) return CR;
        return CBad;
      end
      default: return CBad;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      6'b000100, 6'b000000: return 3'b011;
      6'b000110, 6'b000010: return 3'b100;
      6'b000111, 6'b000011: return 3'b101;
      default: return 3'b010;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one instruction from FETCH with fst fetch stalls and mst memory-phase stalls.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fst, input int mst, input string name);
    int cls, cyc, fl, ml, n_reg, n_pc, n_ir, n_wr, iord_bad;
    int exp_len, exp_reg, exp_pc, exp_wr, exec_cyc;
    bit done, fetched, taken;
    logic rw_addr, rw_data, dec_ok, ex_zext, ex_pcwe;
    logic [1:0] ex_a, ex_b, ex_pcsrc, exp_a, exp_b, exp_pcsrc;
    logic [2:0] ex_alu, exp_alu;
    logic exp_zext;
    cls = ref_class(op, fn);
    operation = op; func = fn; zero = z;
    cyc = 0; fl = fst; ml = mst; n_reg = 0; n_pc = 0; n_ir = 0; n_wr = 0; iord_bad = 0;
    done = 0; fetched = 0; rw_addr = 0; rw_data = 0; dec_ok = 0;
    ex_a = 0; ex_b = 0; ex_alu = 0; ex_pcsrc = 0; ex_pcwe = 0; ex_zext = 0;
    exec_cyc = fst + 3;
    while (!done && cyc < 40) begin
      cyc++;
      mem_ready = 1'b1;
      #1;
      if (mem_re || mem_we) begin
        if (!fetched && fl > 0) begin mem_ready = 1'b0; fl--; end
        else if (fetched && ml > 0) begin mem_ready = 1'b0; ml--; end
      end
      #1;
      if ((mem_re || mem_we) && (iord !== fetched)) iord_bad++;
      if (reg_we) begin n_reg++; rw_addr = reg_write_addr; rw_data = reg_write_data; end
      if (pc_we) n_pc++;
      if (ir_we) n_ir++;
      if (mem_we && mem_ready) n_wr++;
      if (cyc == fst + 2)
        dec_ok = (alu_src_a == 2'b00) && (alu_src_b == 2'b11) && (alu_controller == 3'b010);
      if (cyc == exec_cyc) begin
        ex_a = alu_src_a; ex_b = alu_src_b; ex_alu = alu_controller;
        ex_pcsrc = pc_src; ex_pcwe = pc_we; ex_zext = imm_zext;
      end
      if (ir_we) fetched = 1;
      if (instr_done) done = 1;
      @(negedge clk);
    end

    taken   = (op == 6'b000100) ? z : !z;
    exp_reg = (cls inside {CLw, CR, CSh, CI}) ? 1 : 0;
    exp_pc  = 1 + (((cls == CBr) && taken) || cls == CJ || cls == CJr ? 1 : 0);
    exp_wr  = (cls == CSw) ? 1 : 0;
    exp_len = ((cls == CLw) ? 5 : (cls inside {CSw, CR, CSh, CI}) ? 4 : 3) + fst +
              ((cls == CLw || cls == CSw) ? mst : 0);
    exp_a = 2'b01; exp_b = 2'b00; exp_alu = 3'b010; exp_pcsrc = 2'b00; exp_zext = 1'b0;
    case (cls)
      CLw, CSw: exp_b = 2'b10;
      CR:  exp_alu = ref_alu(fn);
      CSh: begin exp_a = 2'b10; exp_alu = ref_alu(fn); end
      CI: begin
        exp_b = 2'b10;
        exp_alu = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 : 3'b010;
        exp_zext = (op != 6'b001000);
      end
      CBr: begin exp_alu = 3'b110; exp_pcsrc = 2'b01; end
      CJ:  exp_pcsrc = 2'b10;
      CJr: exp_pcsrc = 2'b11;
      default: ;
    endcase

    checks++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL %s done: got no instr_done within %0d cycles", name, cyc);
    end
    checks++;
    if (cyc !== exp_len) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_len);
    end
    checks++;
    if (n_ir !== 1) begin fails++; $display("FAIL %s ir_we count: got %0d expected 1", name, n_ir); end
    checks++;
    if (n_reg !== exp_reg) begin
      fails++; $display("FAIL %s reg_we count: got %0d expected %0d", name, n_reg, exp_reg);
    end
    checks++;
    if (n_pc !== exp_pc) begin
      fails++; $display("FAIL %s pc_we count: got %0d expected %0d", name, n_pc, exp_pc);
    end
    checks++;
    if (n_wr !== exp_wr) begin
      fails++; $display("FAIL %s mem write count: got %0d expected %0d", name, n_wr, exp_wr);
    end
    checks++;
    if (iord_bad !== 0) begin
      fails++; $display("FAIL %s iord: got %0d wrong cycles expected 0", name, iord_bad);
    end
    checks++;
    if (dec_ok !== 1'b1) begin
      fails++; $display("FAIL %s decode selects: got wrong a/b/alu expected 00/11/010", name);
    end
    if (exp_reg == 1) begin
      checks++;
      if (rw_addr !== (cls == CR || cls == CSh) || rw_data !== (cls == CLw)) begin
        fails++;
        $display("FAIL %s writeback: got addr=%0b data=%0b expected addr=%0b data=%0b",
                 name, rw_addr, rw_data, (cls == CR || cls == CSh), (cls == CLw));
      end
    end
    if (!(cls inside {CJ, CJr})) begin
      checks++;
      if (ex_a !== exp_a || ex_b !== exp_b || ex_alu !== exp_alu) begin
        fails++;
        $display("FAIL %s exec: got a=%b b=%b alu=%b expected a=%b b=%b alu=%b",
                 name, ex_a, ex_b, ex_alu, exp_a, exp_b, exp_alu);
      end
    end
    if (cls inside {CBr, CJ, CJr}) begin
      checks++;
      if (ex_pcsrc !== exp_pcsrc || ex_pcwe !== ((cls == CBr) ? taken : 1'b1)) begin
        fails++;
        $display("FAIL %s pc update: got src=%b we=%b expected src=%b we=%b",
                 name, ex_pcsrc, ex_pcwe, exp_pcsrc, (cls == CBr) ? taken : 1'b1);
      end
    end
    if (cls == CI) begin
      checks++;
      if (ex_zext !== exp_zext) begin
        fails++; $display("FAIL %s imm_zext: got %b expected %b", name, ex_zext, exp_zext);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({pc_we, ir_we, mem_re, mem_we, reg_we, instr_done} !== 6'b0) begin
      fails++;
      $display("FAIL reset strobes: got %b expected 000000",
               {pc_we, ir_we, mem_re, mem_we, reg_we, instr_done});
    end
    checks++;
    if ({mem_err, illegal_op} !== 2'b00) begin
      fails++; $display("FAIL reset flags: got %b expected 00", {mem_err, illegal_op});
    end
    checks++;
    if ({pc_src, iord, alu_src_a, alu_src_b, reg_write_addr, reg_write_data, imm_zext} !== 10'b0)
    begin
      fails++; $display("FAIL reset selects: got nonzero expected all 0");
    end
    checks++;
    if (alu_controller !== 3'b010) begin
      fails++; $display("FAIL reset alu_controller: got %b expected 010", alu_controller);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_re !== 1'b1 || iord !== 1'b0 || alu_src_b !== 2'b01) begin
      fails++;
      $display("FAIL reset fetch: got mem_re=%b iord=%b b=%b expected 1 0 01",
               mem_re, iord, alu_src_b);
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_add();
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "add");
  endtask

  task automatic test_lw_stall();
    run_instr(6'b100011, 6'd0, 1'b0, 0, 2, "lw_stall");
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0, "beq_taken");
    run_instr(6'b000101, 6'd0, 1'b1, 0, 0, "bne_not_taken");
  endtask

  task automatic test_random();
    int idx, cls;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 19);
      cls = ref_class(instr_tbl[idx][11:6], instr_tbl[idx][5:0]);
      run_instr(instr_tbl[idx][11:6], instr_tbl[idx][5:0], 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), (cls == CLw || cls == CSw) ? $urandom_range(0, 3) : 0,
                "random");
    end
    checks++;
    if (mem_err !== 1'b0) begin
      fails++; $display("FAIL random mem_err: got %b expected 0", mem_err);
    end
  endtask

  task automatic test_timeout();
    int n_ir;
    n_ir = 0;
    operation = 6'b000000; func = 6'b100000;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (mem_err !== 1'b0) begin
        fails++; $display("FAIL timeout early: got mem_err=%b after %0d stalls expected 0", mem_err, i);
      end
      if (ir_we) n_ir++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (mem_err !== 1'b1) begin
      fails++; $display("FAIL timeout flag: got mem_err=%b expected 1", mem_err);
    end
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ir_we) n_ir++;
      @(negedge clk);
    end
    checks++;
    if (n_ir !== 0) begin fails++; $display("FAIL timeout ir_we: got %0d expected 0", n_ir); end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_re !== 1'b1 || ir_we !== 1'b1 || mem_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout refetch: got mem_re=%b ir_we=%b mem_err=%b expected 1 1 1",
               mem_re, ir_we, mem_err);
    end
    @(negedge clk);
    do_reset();
    #1;
    checks++;
    if (mem_err !== 1'b0) begin
      fails++; $display("FAIL timeout clear: got mem_err=%b expected 0", mem_err);
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    int n_reg;
    seen = 0; n_reg = 0;
    operation = 6'b101011; func = 6'd0; mem_ready = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (mem_we) begin seen = 1; mem_ready = 1'b0; end
      if (reg_we) n_reg++;
      if (!seen) @(negedge clk);
    end
    checks++;
    if (!seen) begin fails++; $display("FAIL midwrite reach: got no mem_we expected MEM_WR"); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_we, ir_we, mem_re, mem_we, reg_we, instr_done} !== 6'b0) begin
      fails++;
      $display("FAIL midwrite strobes: got %b expected 000000",
               {pc_we, ir_we, mem_re, mem_we, reg_we, instr_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      if (i == 1) begin
        checks++;
        if (mem_re !== 1'b1 || iord !== 1'b0) begin
          fails++; $display("FAIL midwrite refetch: got mem_re=%b iord=%b expected 1 0", mem_re, iord);
        end
      end
      if (reg_we) n_reg++;
      if (i == 4) begin
        checks++;
        if (instr_done !== 1'b1) begin
          fails++; $display("FAIL midwrite sw redo: got instr_done=%b expected 1", instr_done);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n_reg !== 0) begin fails++; $display("FAIL midwrite reg_we: got %0d expected 0", n_reg); end
  endtask

  task automatic test_illegal();
    int bad;
    bad = 0;
    operation = 6'b111111; func = 6'd0; mem_ready = 1'b1;
    #1;
    checks++;
    if (ir_we !== 1'b1) begin fails++; $display("FAIL illegal fetch: got ir_we=%b expected 1", ir_we); end
    @(negedge clk);
    #1;
`ifdef MC_ILLEGAL_TRAP_EN
    checks++;
    if (instr_done !== 1'b0) begin
      fails++; $display("FAIL illegal decode: got instr_done=%b expected 0", instr_done);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (illegal_op !== 1'b1 || {pc_we, ir_we, mem_re, mem_we, reg_we, instr_done} !== 6'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL illegal trap: got %0d bad cycles expected 0", bad); end
`else
    checks++;
    if (instr_done !== 1'b1) begin
      fails++; $display("FAIL illegal decode: got instr_done=%b expected 1", instr_done);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem_re !== 1'b1 || iord !== 1'b0 || illegal_op !== 1'b0) begin
      fails++;
      $display("FAIL illegal nop: got mem_re=%b iord=%b illegal_op=%b expected 1 0 0",
               mem_re, iord, illegal_op);
    end
    @(negedge clk);
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_random();
    test_timeout();
    test_reset_mid_write();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
